text_vram_ctrl: RTL and testbench
=================================

# text_vram_ctrl

Parametrised single-clock text-mode video RAM with an integrated cursor engine: accepts ASCII codes from the keyboard decoder through a valid/ready handshake, places them at a managed cursor with newline, backspace and line-wrap handling, and serves a registered character read port to the VGA character generator. Scrolling uses a circular top-row offset. Blank fill on reset and on each new line is done by an internal clear engine. It sits between the PS/2 ASCII decoder and the VGA glyph lookup, replacing the dual-clock fixed 4096-entry buffer.

## Interface
- COLS, 70, characters per row (>=2)
- ROWS, 30, rows on screen (>=2)
- AW, 12, memory address width; COLS*ROWS <= 2^AW
- SCROLL, 1, 1 = scroll on bottom overflow; 0 = wrap cursor to row 0
- BLANK, 8'h20, fill code written by the clear engine

- VGA_CLK  in  1  sole clock; the decoder side must be synchronised to it upstream
- RST  in  1  synchronous, active-high reset
- key_valid  in  1  ascii holds a code
- key_ascii  in  8  code from the keyboard decoder
- key_ready  out  1  block can accept a code this cycle
- rd_row  in  clog2(ROWS)  screen row requested by VGA
- rd_col  in  clog2(COLS)  screen column requested by VGA
- rd_data  out  8  character at (rd_row, rd_col), registered
- cur_row  out  clog2(ROWS)  cursor screen row
- cur_col  out  clog2(COLS)  cursor column
- now_ascii  out  8  last printable code written
- busy  out  1  clear engine active (INIT or CLEAR)

## Operation
- States: INIT, IDLE, CLEAR. key_ready = (state==IDLE).
- INIT: writes BLANK to physical addresses 0..COLS*ROWS-1, one per cycle. Then enters IDLE.
- Accept: key_valid && key_ready. Each accepted code is consumed exactly once.
- Printable codes 0x20..0xFB:
  - Write the code at the cursor. now_ascii = code.
  - If cur_col < COLS-1: cur_col+1. Otherwise perform a newline.
- 0x0D (enter): perform a newline.
- 0x08 (backspace):
  - If cur_col > 0: cur_col-1.
  - Else if cur_row > 0: cur_row-1, cur_col = COLS-1.
  - Write BLANK at the new position.
  - At (0,0): no-op.
- All other codes (0x00..0x1F except 0x08/0x0D, and 0xFC..0xFF): consumed with no effect.
- Newline:
  - cur_col = 0.
  - If cur_row < ROWS-1: cur_row+1, no clear.
  - Else if SCROLL=1: cur_row stays ROWS-1, top advances by 1 mod ROWS, and the new bottom row is cleared.
  - Else (SCROLL=0): cur_row = 0 and row 0 is cleared.
- CLEAR: writes BLANK to the COLS cells of the target physical row, one per cycle. Then enters IDLE.
- Physical row = (screen_row + top) mod ROWS. Physical address = phys_row*COLS + col.
  - Computed without a divider: a conditional subtract of ROWS, since both operands are < ROWS.
  - Applies to both the write and read paths.
- Read port is independent of state; VGA reads continue during INIT and CLEAR.

## Timing
- Reset values:
  - state = INIT, key_ready = 0, busy = 1.
  - rd_data, cur_row, cur_col, now_ascii, top = 0.
  - Clear counter = 0.
- RST asserted in any state, including mid-INIT or mid-CLEAR: restart INIT from address 0 on the next cycle. Pending codes are discarded.
- INIT takes COLS*ROWS cycles. key_ready rises on the cycle after the last blank write.
- Accepted code:
  - The memory write happens at the accepting edge.
  - cur_row, cur_col, now_ascii and top update at the same edge, so they are visible the next cycle.
- A newline that needs a clear:
  - key_ready drops the cycle after acceptance.
  - It stays low for exactly COLS cycles, then returns high.
- Back-to-back codes without a clear: one accepted per cycle.
- Read latency: 1 cycle. rd_data at edge N+1 reflects the address presented at edge N.
- Same-cycle write and read of one cell: rd_data returns the old value (read-before-write).

## Test plan
Parameters for all scenarios: COLS=4, ROWS=3, SCROLL=1.

- Reset/INIT: pulse RST, hold key_valid=1 -> key_ready=0 for 12 cycles, then 1. All 12 cells read 0x20, cursor (0,0).
- Write/wrap: send 'A','B','C','D','E' -> row 0 reads "ABCD", (1,0)='E', cursor (1,1), now_ascii=0x45.
- Backspace: after the above, send 0x08 twice -> (1,0)=0x20, cursor (1,0) after the first, then (0,3) with (0,3)=0x20 after the second. 0x08 at (0,0) -> no change.
- Scroll: fill to row 2 and send 0x0D -> top=1, key_ready low 4 cycles. Screen row 0 shows the old row 1, screen row 2 is all 0x20, cursor (2,0).
- Filtering/read hazard: send 0xFF, 0x1B -> cursor and memory unchanged, each consumed in 1 cycle. Read cell (0,0) in the same cycle it is written 'Z' -> old value, then 'Z' on the next read.
- Reset mid-CLEAR: assert RST 2 cycles into a line clear -> INIT restarts, 12-cycle blank fill, top=0, cursor (0,0).

Source files
------------

// File: rtl/text_vram_ctrl_if.sv
// Keyboard handshake and VGA read port of the text video RAM.
// The master side drives codes and read addresses; the slave is the RAM.
interface text_vram_ctrl_if #(
    parameter int COLS = 70,
    parameter int ROWS = 30
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          key_valid;
    logic [7:0]    key_ascii;
    logic          key_ready;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [7:0]    rd_data;

    modport master (
        output key_valid, key_ascii, rd_row, rd_col,
        input  key_ready, rd_data
    );

    modport slave (
        input  key_valid, key_ascii, rd_row, rd_col,
        output key_ready, rd_data
    );
endinterface

// File: rtl/text_vram_ctrl.sv
// Text-mode video RAM with cursor engine, circular scrolling and a
// clear engine that blanks the screen on reset and each new line.
module text_vram_ctrl #(
    parameter int         COLS   = 70,
    parameter int         ROWS   = 30,
    parameter int         AW     = 12,
    parameter bit         SCROLL = 1'b1,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic                     VGA_CLK,
    input  logic                     RST,
    text_vram_ctrl_if.slave          bus,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic [7:0]               now_ascii,
    output logic                     busy
);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] top_q, top_d;
    logic [RW-1:0] clr_row_q, clr_row_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]    now_q, now_d;

    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic          do_nl;
    logic          bs_wr;
    logic [AW-1:0] rd_addr;

    // Full addressable depth keeps every AW-bit address in range.
    logic [7:0] mem [2**AW];

    // Screen row -> physical row via the circular top offset; both operands
    // are below ROWS, so a single conditional subtract replaces a modulo.
    function automatic logic [AW-1:0] phys_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= (RW+1)'(ROWS))
            sum = sum - (RW+1)'(ROWS);
        return AW'(sum) * AW'(COLS) + AW'(col);
    endfunction

    assign bus.key_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign cur_row       = cur_row_q;
    assign cur_col       = cur_col_q;
    assign now_ascii     = now_q;
    assign rd_addr       = phys_addr(bus.rd_row, bus.rd_col, top_q);

    // Next-state, cursor update and memory write request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        top_d     = top_q;
        clr_row_d = clr_row_q;
        clr_cnt_d = clr_cnt_q;
        now_d     = now_q;
        we        = 1'b0;
        wa        = '0;
        wd        = BLANK;
        do_nl     = 1'b0;
        bs_wr     = 1'b0;

        case (state_q)
            INIT: begin
                we = 1'b1;
                wa = clr_cnt_q;
                if (clr_cnt_q == AW'(CELLS - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            CLEAR: begin
                we = 1'b1;
                wa = AW'(clr_row_q) * AW'(COLS) + clr_cnt_q;
                if (clr_cnt_q == AW'(COLS - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            default: begin
                if (bus.key_valid) begin
                    if (bus.key_ascii >= 8'h20 && bus.key_ascii <= 8'hFB) begin
                        we    = 1'b1;
                        wd    = bus.key_ascii;
                        wa    = phys_addr(cur_row_q, cur_col_q, top_q);
                        now_d = bus.key_ascii;
                        if (cur_col_q < CW'(COLS - 1))
                            cur_col_d = cur_col_q + 1'b1;
                        else
                            do_nl = 1'b1;
                    end else if (bus.key_ascii == 8'h0D) begin
                        do_nl = 1'b1;
                    end else if (bus.key_ascii == 8'h08) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - 1'b1;
                            bs_wr     = 1'b1;
                        end else if (cur_row_q != '0) begin
                            cur_row_d = cur_row_q - 1'b1;
                            cur_col_d = CW'(COLS - 1);
                            bs_wr     = 1'b1;
                        end
                        if (bs_wr) begin
                            we = 1'b1;
                            wa = phys_addr(cur_row_d, cur_col_d, top_q);
                        end
                    end

                    if (do_nl) begin
                        cur_col_d = '0;
                        if (cur_row_q < RW'(ROWS - 1)) begin
                            cur_row_d = cur_row_q + 1'b1;
                        end else begin
                            // The row to blank is physically the old top in
                            // both modes: after a scroll it becomes the new
                            // bottom, without scroll it is screen row 0.
                            clr_row_d = top_q;
                            clr_cnt_d = '0;
                            state_d   = CLEAR;
                            if (SCROLL)
                                top_d = (top_q == RW'(ROWS - 1)) ? '0 : top_q + 1'b1;
                            else
                                cur_row_d = '0;
                        end
                    end
                end
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge VGA_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q   <= INIT;
            cur_row_q <= '0;
            cur_col_q <= '0;
            top_q     <= '0;
            clr_row_q <= '0;
            clr_cnt_q <= '0;
            now_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            top_q     <= top_d;
            clr_row_q <= clr_row_d;
            clr_cnt_q <= clr_cnt_d;
            now_q     <= now_d;
        end
    end

    // Character store write port; blocked while reset is held.
    always_ff @(posedge VGA_CLK) begin
        // NOTE: the array itself has no reset so it maps onto block RAM;
        // the INIT sweep provides the blank contents instead.
        if (we && !RST)
            mem[wa] <= wd;
    end

    // Registered read port; returns the pre-write value on a same-cell hit.
    always_ff @(posedge VGA_CLK) begin
        if (RST)
            bus.rd_data <= '0;
        else
            bus.rd_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_text_vram_ctrl.sv
// Self-checking bench for text_vram_ctrl with COLS=4, ROWS=3, SCROLL=1.
module tb_text_vram_ctrl;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    text_vram_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus();

    logic [1:0] cur_row;
    logic [1:0] cur_col;
    logic [7:0] now_ascii;
    logic       busy;

    text_vram_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .AW(AW), .SCROLL(1'b1), .BLANK(8'h20)
    ) dut (
        .VGA_CLK   (clk),
        .RST       (rst),
        .bus       (bus),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .now_ascii (now_ascii),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] now;
    } cur_exp_t;

    typedef struct {
        logic [7:0] code;
        logic [1:0] exp_row;
        logic [1:0] exp_col;
        logic [7:0] exp_now;
        logic [1:0] rd_r;
        logic [1:0] rd_c;
        logic [7:0] rd_exp;
    } vec_t;

    cur_exp_t   cur_q[$];
    logic [7:0] rd_q[$];
    vec_t       vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        int n;
        n = 0;
        while (!bus.key_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", bus.key_ready, 1);
        bus.key_valid = 1'b1;
        bus.key_ascii = code;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name);
        cur_exp_t e;
        e = cur_q.pop_front();
        check({name, "_row"}, cur_row, e.row);
        check({name, "_col"}, cur_col, e.col);
        check({name, "_now"}, now_ascii, e.now);
    endtask

    task automatic read_chk(input int r, input int c, input logic [7:0] exp);
        bus.rd_row = 2'(r);
        bus.rd_col = 2'(c);
        rd_q.push_back(exp);
        tick();
        check($sformatf("rd(%0d,%0d)", r, c), bus.rd_data, rd_q.pop_front());
    endtask

    task automatic read_row(input int r, input string s);
        for (int c = 0; c < COLS; c++)
            read_chk(r, c, s[c]);
    endtask

    // key_ready must stay low for n sampled cycles and then rise.
    task automatic expect_busy_for(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check({name, "_ready_low"}, bus.key_ready, 0);
            check({name, "_busy"}, busy, 1);
            tick();
        end
        check({name, "_ready_high"}, bus.key_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{8'h41, 2'd0, 2'd1, 8'h41, 2'd0, 2'd0, 8'h41};
        vecs[1]  = '{8'h42, 2'd0, 2'd2, 8'h42, 2'd0, 2'd1, 8'h42};
        vecs[2]  = '{8'h43, 2'd0, 2'd3, 8'h43, 2'd0, 2'd2, 8'h43};
        vecs[3]  = '{8'h44, 2'd1, 2'd0, 8'h44, 2'd0, 2'd3, 8'h44};
        vecs[4]  = '{8'h45, 2'd1, 2'd1, 8'h45, 2'd1, 2'd0, 8'h45};
        vecs[5]  = '{8'h08, 2'd1, 2'd0, 8'h45, 2'd1, 2'd0, 8'h20};
        vecs[6]  = '{8'h08, 2'd0, 2'd3, 8'h45, 2'd0, 2'd3, 8'h20};
        vecs[7]  = '{8'hFF, 2'd0, 2'd3, 8'h45, 2'd0, 2'd2, 8'h43};
        vecs[8]  = '{8'h1B, 2'd0, 2'd3, 8'h45, 2'd1, 2'd1, 8'h20};
        vecs[9]  = '{8'h08, 2'd0, 2'd2, 8'h45, 2'd0, 2'd2, 8'h20};
        vecs[10] = '{8'h08, 2'd0, 2'd1, 8'h45, 2'd0, 2'd1, 8'h20};
        vecs[11] = '{8'h08, 2'd0, 2'd0, 8'h45, 2'd0, 2'd0, 8'h20};
        vecs[12] = '{8'h08, 2'd0, 2'd0, 8'h45, 2'd1, 2'd0, 8'h20};

        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.rd_row    = 2'd0;
        bus.rd_col    = 2'd0;
        tick();

        // Reset with a code held valid: nothing may be taken during INIT.
        rst           = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_ascii = 8'h00;
        tick();
        check("rst_ready", bus.key_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_row", cur_row, 0);
        check("rst_col", cur_col, 0);
        check("rst_now", now_ascii, 0);
        check("rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;
        expect_busy_for(COLS * ROWS, "init");
        bus.key_valid = 1'b0;
        for (int r = 0; r < ROWS; r++)
            read_row(r, "    ");
        check("init_row", cur_row, 0);
        check("init_col", cur_col, 0);

        // Same-cycle write and read of (0,0): old value first, then the new one.
        bus.rd_row = 2'd0;
        bus.rd_col = 2'd0;
        rd_q.push_back(8'h20);
        cur_q.push_back('{2'd0, 2'd1, 8'h5A});
        send(8'h5A);
        check("hazard_old", bus.rd_data, rd_q.pop_front());
        check_cursor("hazard");
        rd_q.push_back(8'h5A);
        tick();
        check("hazard_new", bus.rd_data, rd_q.pop_front());
        cur_q.push_back('{2'd0, 2'd0, 8'h5A});
        send(8'h08);
        check_cursor("hazard_bs");

        // Table: writes, wrap, backspaces, filtered codes, backspace at origin.
        for (int i = 0; i < 13; i++) begin
            cur_q.push_back('{vecs[i].exp_row, vecs[i].exp_col, vecs[i].exp_now});
            send(vecs[i].code);
            check_cursor($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ready", i), bus.key_ready, 1);
            read_chk(int'(vecs[i].rd_r), int'(vecs[i].rd_c), vecs[i].rd_exp);
        end

        // Fill three rows, then overflow the bottom with enter to scroll.
        send("W"); send("X"); send("Y"); send("Z");
        send("P"); send("Q"); send("R"); send("S");
        send("K");
        cur_q.push_back('{2'd2, 2'd2, 8'h4C});
        send("L");
        check_cursor("fill");
        cur_q.push_back('{2'd2, 2'd0, 8'h4C});
        send(8'h0D);
        check_cursor("scroll");
        check("scroll_top", dut.top_q, 1);
        expect_busy_for(COLS, "scroll");
        read_row(0, "PQRS");
        read_row(1, "KL  ");
        read_row(2, "    ");

        // Reset two cycles into a line clear.
        send(8'h0D);
        check("clr2_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midclr_ready", bus.key_ready, 0);
        check("midclr_row", cur_row, 0);
        check("midclr_col", cur_col, 0);
        check("midclr_now", now_ascii, 0);
        check("midclr_top", dut.top_q, 0);
        rst = 1'b0;
        expect_busy_for(COLS * ROWS, "reinit");
        for (int r = 0; r < ROWS; r++)
            read_row(r, "    ");
        cur_q.push_back('{2'd0, 2'd1, 8'h4D});
        send("M");
        check_cursor("post_reinit");
        read_chk(0, 0, 8'h4D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
